// File: rtl/fifo_rd_stream.sv
// Read-side adapter: drains a one-cycle-latency FIFO read port into a
// valid/ready stream through a 2-entry skid buffer, counting handshakes.
module fifo_rd_stream #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  xfer_count,
    output logic                  underflow_err
);

    // Stream handshake: a word transfers on every rising edge where
    // m_valid && m_ready; m_valid never drops and m_data never changes
    // before that transfer, except when flush discards the buffer.

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [FIFO_WIDTH-1:0] buf0_q, buf0_d;
    logic [FIFO_WIDTH-1:0] buf1_q, buf1_d;
    logic [CNT_WIDTH-1:0]  xfer_count_q, xfer_count_d;
    logic                  underflow_err_q, underflow_err_d;

    logic                  pop;
    logic                  push;
    logic [2:0]            held_after_pop;

    assign m_valid       = (occ_q != 2'd0);
    assign m_data        = buf0_q;
    assign xfer_count    = xfer_count_q;
    assign underflow_err = underflow_err_q;

    assign pop  = m_valid && m_ready;
    assign push = inflight_q && !flush;

    // Words still owned after this cycle's pop: buffered plus the one in flight.
    // pop implies occ_q >= 1, so the subtraction never wraps.
    assign held_after_pop = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

    assign fifo_rd_en = rst_n && !flush && !fifo_empty && (held_after_pop <= 3'd1);

    always_comb begin
        occ_d  = occ_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        unique case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    buf0_d = fifo_data_out;
                end else begin
                    buf1_d = fifo_data_out;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                if (occ_q == 2'd2) begin
                    buf0_d = buf1_q;
                end
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = fifo_data_out;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_data_out;
                end
            end
            default: begin
            end
        endcase
        if (flush) begin
            occ_d = 2'd0;
        end
    end

    always_comb begin
        inflight_d      = fifo_rd_en;
        xfer_count_d    = pop ? xfer_count_q + CNT_WIDTH'(1) : xfer_count_q;
        underflow_err_d = underflow_err_q || fifo_underflow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q           <= 2'd0;
            inflight_q      <= 1'b0;
            buf0_q          <= '0;
            buf1_q          <= '0;
            xfer_count_q    <= '0;
            underflow_err_q <= 1'b0;
        end else begin
            occ_q           <= occ_d;
            inflight_q      <= inflight_d;
            buf0_q          <= buf0_d;
            buf1_q          <= buf1_d;
            xfer_count_q    <= xfer_count_d;
            underflow_err_q <= underflow_err_d;
        end
    end

`ifndef SYNTHESIS
    // A push into a full buffer without a matching pop would lose a word.
    a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (occ_q == 2'd2) && !pop));

    a_no_empty_read: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_rd_en && fifo_empty));
`endif

endmodule
